fxp_umul_iter: RTL
==================

// Module: fxp_umul_iter
// PURPOSE
//  Iterative unsigned fixed-point multiplier with val/rdy stream interfaces.
//  Parametrised successor of the 8b Q4.4 combinational multiplier: generic
//  width, fraction bits and overflow policy (zero or saturate).
//  Shift-add datapath, one partial product per cycle.
//  Sits in arithmetic-unit pipelines where area matters more than throughput.
// PARAMETERS
//  p_nbits   8  operand/result width N (>=2)
//  p_nfrac   4  fraction bits F, 0 <= F < N; format Q(N-F).F for in0/in1/out
//  p_sat     0  overflow policy: 0 -> out forced to 0, 1 -> out forced to all ones
// PORTS
//  clk           in   1  clock, all state updates on rising edge
//  reset         in   1  asynchronous, active-high reset
//  istream_val   in   1  operands valid
//  istream_rdy   out  1  block can accept operands
//  in0           in   N  multiplicand, Q(N-F).F unsigned
//  in1           in   N  multiplier, Q(N-F).F unsigned
//  ostream_val   out  1  result valid
//  ostream_rdy   in   1  consumer accepts result
//  out           out  N  product, Q(N-F).F unsigned
//  overflow      out  1  product not representable in N bits; qualified by ostream_val
// BEHAVIOUR
//  Reset: state=IDLE, istream_rdy=1, ostream_val=0, out=0, overflow=0, acc/count=0.
//  The reset is asynchronous: asserting it at any point, including mid-CALC or
//  in DONE, aborts the operation immediately. The pending result is lost and
//  is never emitted.
//  FSM states: IDLE, CALC, DONE.
//  - IDLE: istream_rdy=1, ostream_val=0.
//    On istream_val, the next edge does the following:
//      a   <= zext(in0) to 2N bits
//      b   <= in1
//      acc <= 0
//      cnt <= 0
//      state -> CALC
//  - CALC: istream_rdy=0, ostream_val=0. Each cycle:
//      if b[0], acc <= acc + a  (2N-bit, cannot wrap)
//      a <= a<<1;  b <= b>>1;  cnt++
//    After exactly N CALC cycles, state -> DONE. There is no early exit for
//    zero operands: latency is fixed.
//  - DONE: ostream_val=1, istream_rdy=0. out/overflow are held stable until
//    ostream_rdy=1. On that handshake edge, state -> IDLE.
//  Latency/throughput:
//    - Input handshake in cycle 0 -> ostream_val first high in cycle N+1.
//    - Minimum issue interval is N+2 cycles; there is no same-cycle
//      output-retire / input-accept.
//  Result arithmetic, with P = acc (2N bits, full Q(2N-2F).2F product):
//    - overflow = |P[2N-1:N+F]
//    - out = overflow ? (p_sat ? {N{1'b1}} : 0) : P[N+F-1:F]
//  Fraction bits below F are truncated (no rounding).
//  out and overflow are registered/derived from acc; they are driven 0
//  outside DONE.
//  istream_val while busy: ignored, since rdy=0. Inputs are sampled only on
//  the handshake edge.
//  cnt width is $clog2(N)+1. The terminal test is cnt==N-1 while in CALC.
// STRUCTURE
//  Package fxp_mul_pkg:
//    - state enum {IDLE, CALC, DONE}
//    - localparam helper for the counter width
//  Sub-modules, wired at the top level:
//    - fxp_umul_iter_dpath: a/b/acc/cnt registers, adder, output slice and
//      overflow logic
//    - fxp_umul_iter: FSM and handshake control
// TESTING  (N=8, F=4 unless noted; ostream_rdy=1 unless noted)
//  1. in0=0x18, in1=0x28 (1.5*2.5) -> out=0x3C, overflow=0;
//     ostream_val rises exactly 9 cycles after accept.
//  2. in0=0x40, in1=0x40 (4*4), p_sat=0 -> out=0x00, overflow=1;
//     with p_sat=1 -> out=0xFF, overflow=1.
//  3. in0=0xFF, in1=0x01 -> out=0x0F, overflow=0;
//     in0=0x00, in1=0xFF -> out=0x00, latency still 9 cycles.
//  4. Backpressure: ostream_rdy=0 for 5 cycles in DONE -> out and overflow
//     stable, istream_rdy=0 throughout; next input accepted only after the
//     output handshake and return to IDLE.
//  5. Reset asserted mid-CALC -> ostream_val=0 and istream_rdy=1 immediately,
//     no result emitted; next op 0x10*0x10 -> out=0x10.
//  6. N=16, F=8: in0=0x0180, in1=0x0200 -> out=0x0300, overflow=0;
//     in0=0xFFFF, in1=0x0200 -> overflow=1.
//     Random sweep vs golden (in0*in1)>>F with back-to-back traffic.

Source files
------------

// File: rtl/fxp_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_mul_pkg
//  Description : Shared types and helpers for the iterative unsigned
//                fixed-point multiplier.
//                  - state_t      : control FSM state encoding
//                  - cnt_width()  : width of the partial-product counter
//  Revision    : 1.0 - initial release
// ============================================================================
package fxp_mul_pkg;

    // Control FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter is wide enough to hold N itself, not just N-1.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits) + 1;
    endfunction

endpackage : fxp_mul_pkg
`default_nettype wire

// File: rtl/fxp_umul_iter_dpath.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_umul_iter_dpath
//  Description : Shift-add datapath for the iterative unsigned multiplier.
//                Holds the shifted multiplicand (a), the shifted multiplier
//                (b), the 2N-bit accumulator and the cycle counter. Produces
//                the Q(N-F).F result slice and the overflow flag, both gated
//                to zero outside the DONE state.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                i_load          - capture operands, clear acc/cnt
//                i_calc          - perform one partial-product step
//                i_done          - result is being presented
//                i_in0, i_in1    - operands (N bits)
//                o_last          - current step is the final one
//                o_out           - product slice (N bits)
//                o_overflow      - product not representable in N bits
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_umul_iter_dpath
    import fxp_mul_pkg::*;
#(
    parameter int P_NBITS = 8,
    parameter int P_NFRAC = 4,
    parameter int P_SAT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_calc,
    input  logic               i_done,
    input  logic [P_NBITS-1:0] i_in0,
    input  logic [P_NBITS-1:0] i_in1,
    output logic               o_last,
    output logic [P_NBITS-1:0] o_out,
    output logic               o_overflow
);

    localparam int c_cw = cnt_width(P_NBITS);
    localparam int c_pw = 2 * P_NBITS;

    // Value presented on overflow: all ones when saturating, zero otherwise.
    localparam logic [P_NBITS-1:0] c_ovf_fill = (P_SAT != 0) ? {P_NBITS{1'b1}}
                                                             : {P_NBITS{1'b0}};

    logic [c_pw-1:0]    r_a;
    logic [P_NBITS-1:0] r_b;
    logic [c_pw-1:0]    r_acc;
    logic [c_cw-1:0]    r_cnt;

    logic [c_pw-1:0]    w_sum;
    logic               w_ovf;
    logic [P_NBITS-1:0] w_slice;

    // The accumulator holds at most (2^N-1)^2 < 2^2N, so this never wraps.
    assign w_sum = r_acc + r_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= {{P_NBITS{1'b0}}, i_in0};
            r_b   <= i_in1;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_calc) begin
            if (r_b[0]) begin
                r_acc <= w_sum;
            end
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

    assign o_last = (r_cnt == c_cw'(P_NBITS - 1));

    // Full product is Q(2N-2F).2F; keep bits [N+F-1:F], anything above is overflow.
    assign w_ovf   = |r_acc[c_pw-1:P_NBITS+P_NFRAC];
    assign w_slice = r_acc[P_NBITS+P_NFRAC-1:P_NFRAC];

    assign o_overflow = i_done & w_ovf;
    assign o_out      = !i_done ? {P_NBITS{1'b0}} :
                        w_ovf   ? c_ovf_fill      : w_slice;

endmodule : fxp_umul_iter_dpath
`default_nettype wire

// File: rtl/fxp_umul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_umul_iter
//  Description : Iterative unsigned fixed-point multiplier, Q(N-F).F format,
//                with val/rdy input and output streams. One partial product
//                per cycle, fixed latency of N CALC cycles, overflow either
//                zeroes or saturates the result.
//  Ports       : clk, reset               - clock, async active-high reset
//                istream_val/istream_rdy  - operand handshake
//                in0, in1                 - multiplicand / multiplier
//                ostream_val/ostream_rdy  - result handshake
//                out, overflow            - product and overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_umul_iter
    import fxp_mul_pkg::*;
#(
    parameter int p_nbits = 8,
    parameter int p_nfrac = 4,
    parameter int p_sat   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [p_nbits-1:0] out,
    output logic               overflow
);

    state_t r_state;
    state_t w_state_next;

    logic w_load;
    logic w_calc;
    logic w_done;
    logic w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_calc       = 1'b0;
        w_done       = 1'b0;
        istream_rdy  = 1'b0;
        ostream_val  = 1'b0;
        case (r_state)
            IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    w_load       = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_calc = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                ostream_val = 1'b1;
                // Retiring goes to IDLE only; a new operand is taken on a later edge.
                if (ostream_rdy) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    fxp_umul_iter_dpath #(
        .P_NBITS (p_nbits),
        .P_NFRAC (p_nfrac),
        .P_SAT   (p_sat)
    ) u_dpath (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_calc     (w_calc),
        .i_done     (w_done),
        .i_in0      (in0),
        .i_in1      (in1),
        .o_last     (w_last),
        .o_out      (out),
        .o_overflow (overflow)
    );

endmodule : fxp_umul_iter
`default_nettype wire
